// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage encodings: destination-source and load-size codes.
package wb_stage_pkg;

  localparam int DEST_SRC_W = 2;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE = 2'd0;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_ALU  = 2'd1;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_MEM  = 2'd2;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_PC4  = 2'd3;

  localparam int LD_SIZE_W = 2;
  localparam logic [LD_SIZE_W-1:0] LD_SIZE_B = 2'd0;
  localparam logic [LD_SIZE_W-1:0] LD_SIZE_H = 2'd1;
  localparam logic [LD_SIZE_W-1:0] LD_SIZE_W_CODE = 2'd2;

endpackage

// File: rtl/wb_load_align.sv
// Purpose: extracts the byte/half/word selected by the low address bits and extends it.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module wb_load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]          mem_read,
  input  logic [1:0]           off,
  input  logic [LD_SIZE_W-1:0] size,
  input  logic                 sgn,
  output logic [DATA_W-1:0]    result
);

  logic [7:0]  byte_dat;
  logic [15:0] half_dat;

  always_comb begin
    byte_dat = 8'(mem_read >> {off, 3'b000});
    // Halves are always 16-bit aligned, so off[0] plays no part.
    half_dat = 16'(mem_read >> {off[1], 4'b0000});
    case (size)
      LD_SIZE_B: result = {{(DATA_W-8){byte_dat[7] & sgn}}, byte_dat};
      LD_SIZE_H: result = {{(DATA_W-16){half_dat[15] & sgn}}, half_dat};
      default:   result = DATA_W'(mem_read);
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Purpose: memory->writeback elastic buffer driving the register-file write port (retire counter with WB_RETIRE_CNT_EN).
// Latency: 1 cycle from push to head visibility.
// Backpressure: o_ready = !full, registered-only, no ready->ready combinational path.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  input  logic [DATA_W-1:0]     i_alu_eval,
  input  logic [31:0]           i_mem_read,
  input  logic [LD_SIZE_W-1:0]  i_ld_size,
  input  logic                  i_ld_signed,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [REG_IDX_W-1:0]  o_dest_reg,
  output logic                  o_we,
  output logic [DATA_W-1:0]     o_dest_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           o_retire_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]     pc;
    logic [DEST_SRC_W-1:0] dest_src;
    logic [REG_IDX_W-1:0]  dest_reg;
    logic [DATA_W-1:0]     alu_eval;
    logic [31:0]           mem_read;
    logic [LD_SIZE_W-1:0]  ld_size;
    logic                  ld_signed;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  entry_t             head;
  logic [DATA_W-1:0]  ld_dat;
  logic [ADDR_W-1:0]  link_pc;

  assign o_ready = (count != CNT_W'(DEPTH));
  assign o_valid = (count != '0);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: i_pc, dest_src: i_dest_src, dest_reg: i_dest_reg,
                         alu_eval: i_alu_eval, mem_read: i_mem_read,
                         ld_size: i_ld_size, ld_signed: i_ld_signed};
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .mem_read (head.mem_read),
    .off      (head.alu_eval[1:0]),
    .size     (head.ld_size),
    .sgn      (head.ld_signed),
    .result   (ld_dat)
  );

  assign link_pc = head.pc + ADDR_W'(4);

  // Empty buffer forces every data output to zero regardless of stale storage.
  always_comb begin
    o_pc        = '0;
    o_dest_reg  = '0;
    o_dest_data = '0;
    o_we        = 1'b0;
    if (o_valid) begin
      o_pc       = head.pc;
      o_dest_reg = head.dest_reg;
      o_we       = (head.dest_src != DEST_SRC_NONE) && (head.dest_reg != '0);
      case (head.dest_src)
        DEST_SRC_ALU: o_dest_data = head.alu_eval;
        DEST_SRC_MEM: o_dest_data = ld_dat;
        DEST_SRC_PC4: o_dest_data = DATA_W'(link_pc);
        default:      o_dest_data = '0;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)              o_retire_cnt <= '0;
    else if (pop && !flush)  o_retire_cnt <= o_retire_cnt + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases from the block description, then random traffic against a queue model.
module tb_wb_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_pc;
  logic [1:0]  i_dest_src;
  logic [4:0]  i_dest_reg;
  logic [31:0] i_alu_eval;
  logic [31:0] i_mem_read;
  logic [1:0]  i_ld_size;
  logic        i_ld_signed;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [4:0]  o_dest_reg;
  logic        o_we;
  logic [31:0] o_dest_data;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] o_retire_cnt;
`endif

  wb_stage #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32), .REG_IDX_W(5)) dut (
    .clk(clk), .clr_n(clr_n), .flush(flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg),
    .i_alu_eval(i_alu_eval), .i_mem_read(i_mem_read), .i_ld_size(i_ld_size),
    .i_ld_signed(i_ld_signed), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
    .o_dest_reg(o_dest_reg), .o_we(o_we), .o_dest_data(o_dest_data)
`ifdef WB_RETIRE_CNT_EN
    , .o_retire_cnt(o_retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [1:0]  size;
    logic        sgn;
  } ent_t;

  ent_t        q[$];
  longint unsigned retired = 0;
  int          total = 0;
  int          bad = 0;

  // Reference write-data rule expressed with plain arithmetic.
  function automatic logic [31:0] exp_data(ent_t e);
    longint unsigned v;
    int off;
    off = int'(e.alu % 4);
    case (e.src)
      2'd1: return e.alu;
      2'd3: return 32'((longint'(e.pc) + 4) % 64'h1_0000_0000);
      2'd2: begin
        if (e.size == 2'd0) begin
          v = (longint'(e.mem) / (longint'(1) << (8 * off))) % 256;
          if (e.sgn && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (e.size == 2'd1) begin
          v = (longint'(e.mem) / (longint'(1) << (16 * (off / 2)))) % 65536;
          if (e.sgn && v >= 32768) v = v + 64'hFFFF_0000;
        end else begin
          v = longint'(e.mem);
        end
        return 32'(v);
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t h;
    bit   v;
    v = (q.size() > 0);
    h = v ? q[0] : '0;
    check({tag, ".valid"}, 64'(o_valid), 64'(v));
    check({tag, ".ready"}, 64'(o_ready), 64'(q.size() < DEPTH));
    check({tag, ".pc"},    64'(o_pc),    v ? 64'(h.pc) : 64'd0);
    check({tag, ".rd"},    64'(o_dest_reg), v ? 64'(h.rd) : 64'd0);
    check({tag, ".we"},    64'(o_we),    64'(v && h.src != 2'd0 && h.rd != 5'd0));
    check({tag, ".data"},  64'(o_dest_data), v ? 64'(exp_data(h)) : 64'd0);
`ifdef WB_RETIRE_CNT_EN
    check({tag, ".retire"}, o_retire_cnt, 64'(retired));
`endif
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [1:0] src,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [1:0] sz, input logic sg);
    i_valid = v; i_pc = pc; i_dest_src = src; i_dest_reg = rd;
    i_alu_eval = alu; i_mem_read = mem; i_ld_size = sz; i_ld_signed = sg;
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then settle.
  task automatic cycle();
    bit do_push, do_pop;
    ent_t e;
    @(posedge clk);
    e = '{pc: i_pc, src: i_dest_src, rd: i_dest_reg, alu: i_alu_eval,
          mem: i_mem_read, size: i_ld_size, sgn: i_ld_signed};
    if (flush) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && i_ready;
      do_push = i_valid && (q.size() < DEPTH);
      if (do_pop) begin
        void'(q.pop_front());
        retired++;
      end
      if (do_push) q.push_back(e);
    end
    #1;
  endtask

  initial begin
    clr_n = 1'b0; flush = 1'b0; i_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk); #1;

    // Fill to capacity with the consumer stalled.
    set_in(1, 32'h100, 2'd1, 5'd5, 32'h1234, 0, 0, 0);
    cycle();
    set_in(1, 32'h104, 2'd1, 5'd6, 32'h5678, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    check_all("fill");
    check("fill.ready0", 64'(o_ready), 64'd0);
    check("fill.head_rd", 64'(o_dest_reg), 64'd5);
    check("fill.head_dat", 64'(o_dest_data), 64'h1234);
    i_ready = 1'b1;
    cycle();
    check_all("drain1");
    check("drain1.rd", 64'(o_dest_reg), 64'd6);
    check("drain1.ready", 64'(o_ready), 64'd1);
    cycle();
    check_all("drain2");

    // Load alignment stream, one entry per cycle.
    set_in(1, 32'h200, 2'd2, 5'd7, 32'h1, 32'h80F1_7F02, 2'd0, 1);
    cycle();
    check_all("ld_b_s");
    check("ld_b_s.dat", 64'(o_dest_data), 64'h0000_007F);
    set_in(1, 32'h204, 2'd2, 5'd8, 32'h2, 32'h80F1_7F02, 2'd1, 1);
    cycle();
    check_all("ld_h_s");
    check("ld_h_s.dat", 64'(o_dest_data), 64'hFFFF_80F1);
    set_in(1, 32'h208, 2'd2, 5'd9, 32'h3, 32'h80F1_7F02, 2'd0, 0);
    cycle();
    check_all("ld_b_u");
    check("ld_b_u.dat", 64'(o_dest_data), 64'h0000_0080);
    set_in(1, 32'hFFFF_FFFC, 2'd3, 5'd1, 32'h0, 0, 0, 0);
    cycle();
    check_all("link");
    check("link.dat", 64'(o_dest_data), 64'd0);
    check("link.we", 64'(o_we), 64'd1);
    set_in(1, 32'h300, 2'd1, 5'd0, 32'hDEAD, 0, 0, 0);
    cycle();
    check_all("x0");
    check("x0.valid", 64'(o_valid), 64'd1);
    check("x0.we", 64'(o_we), 64'd0);
    check("x0.dat", 64'(o_dest_data), 64'hDEAD);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check_all("empty");

    // Flush beats a push with one entry held.
    i_ready = 1'b0;
    set_in(1, 32'h400, 2'd1, 5'd3, 32'hAAAA, 0, 0, 0);
    cycle();
    check_all("hold1");
    flush = 1'b1;
    set_in(1, 32'h404, 2'd1, 5'd4, 32'hBBBB, 0, 0, 0);
    cycle();
    flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    check_all("flush");
    check("flush.valid", 64'(o_valid), 64'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      i_ready = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 15) == 0);
      set_in(1'($urandom_range(0, 1)), $urandom, 2'($urandom), 5'($urandom),
             $urandom, $urandom, 2'($urandom), 1'($urandom));
      cycle();
      check_all("rand");
    end
    flush = 1'b0;

    // Asynchronous reset while holding two entries.
    i_ready = 1'b0;
    set_in(1, 32'h500, 2'd1, 5'd10, 32'h11, 0, 0, 0);
    cycle();
    set_in(1, 32'h504, 2'd1, 5'd11, 32'h22, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    check_all("pre_rst");
    #2;
    clr_n = 1'b0;
    #1;
    q.delete();
    retired = 0;
    check_all("async_rst");
    check("async_rst.ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    clr_n = 1'b1;
    cycle();
    check_all("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
